reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks in-flight register writes for the MIPS pipeline: the producer/writer side of operand forwarding.
- A destination is marked pending when an instruction issues from D into E. It is cleared when that write retires in W.
- Decode stalls when a source operand is pending and no forwarding path can yet supply it. This covers load-use and multi-cycle mul/div results.
- Sits beside the forwarding mux. It drives that mux's stall input and exposes the pending vector for debug.

Parameters:
- CNT_W, 2, width of per-register outstanding-write counter; max outstanding writes to one register = 2**CNT_W-1.
- MAX_INFLIGHT, 4, limit on total outstanding writes across all registers.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- issue_valid  input  1  instruction in D requests issue.
- issue_wr  input  1  issuing instruction writes a register.
- issue_rd  input  5  destination register of issuing instruction.
- issue_late  input  1  result is not forwardable from E (load, mul/div); only these are tracked.
- rs_d  input  5  source register rs in D.
- rt_d  input  5  source register rt in D.
- issue_ready  output  1  issue accepted this cycle (the inverse of stall).
- wb_valid  input  1  a tracked write retires in W this cycle.
- wb_rd  input  5  register retiring.
- flush  input  1  synchronous clear of all tracking (exception/branch flush).
- pending  output  32  bit i = 1 when counter[i] != 0; bit 0 always 0.
- inflight  output  $clog2(MAX_INFLIGHT+1)  total outstanding tracked writes.
- overflow_err  output  1  sticky: wb_valid arrived for a register whose counter is 0.

Behaviour:
- Reset (resetn=0, async): all counters 0, inflight 0, overflow_err 0. Therefore pending=0 and issue_ready=1 while issue_valid is don't-care.
- Tracked issue: track = issue_valid & issue_wr & issue_late & (issue_rd != 0) & issue_ready.
- Register 0 is never tracked. Sources equal to 0 never stall.
- Source hazard: hz_s = (rs_d != 0) & (cnt[rs_d] != 0) & ~(wb_valid & wb_rd == rs_d & cnt[rs_d] == 1). hz_t is defined the same way with rt_d.
  - A write retiring in W on the same cycle is forwarded by the W path and does not stall.
- Structural stall occurs when issue_valid & issue_wr & issue_late & (issue_rd != 0) and either condition holds:
  - cnt[issue_rd] == 2**CNT_W-1;
  - inflight == MAX_INFLIGHT and no wb_valid this cycle.
- issue_ready = ~(issue_valid & (hz_s | hz_t | structural)). This is combinational, zero latency. issue_ready=1 when issue_valid=0.
- Counter update on the clock edge, per register r:
  - +1 if the tracked issue targets r;
  - -1 if wb_valid targets r and cnt[r] != 0;
  - both on the same cycle gives no change.
- inflight updates by the same rule: tracked issue +1, valid retire -1, both gives no change.
- wb_valid with cnt[wb_rd]==0 (or wb_rd==0): counter unchanged, overflow_err set to 1. It stays 1 until reset.
- flush=1: next cycle all counters and inflight are 0, regardless of issue/wb that cycle. flush does not clear overflow_err. issue_ready is still computed normally during the flush cycle.
- Counters never wrap: saturation is prevented by the structural stall, and underflow by the overflow_err rule.
- Reset mid-operation: all state cleared immediately; the next retire for an old write raises overflow_err, which is the intended signalling.

Decomposition:
- Shared package (cpu_pkg): typedef creg_t = logic[4:0], constant REG_ZERO = 5'd0, typedef scb_cnt_t = logic[CNT_W-1:0].
- One natural sub-module: scb_counter, a single up/down saturating counter with inc, dec, clr and is_zero/is_one/is_max flags, instantiated 31 times (r1..r31) via generate.

Test Plan:
- Load-use: issue lw with issue_rd=8, issue_late=1; next cycle rs_d=8 -> issue_ready=0, pending[8]=1. Then assert wb_valid, wb_rd=8 -> issue_ready=1 that same cycle, pending[8]=0 the cycle after.
- Same-cycle issue+retire on r5 (cnt[5]=1): issue_rd=5 and wb_rd=5 together -> cnt[5] stays 1, inflight unchanged, pending[5]=1.
- Saturation with CNT_W=2: three tracked issues to r3 with no retire -> fourth issue to r3 gets issue_ready=0. One retire -> issue_ready=1.
- MAX_INFLIGHT=4: four tracked issues to r1..r4 -> issue to r6 stalls. Same cycle wb_valid on r1 -> issue_ready=1, inflight stays 4.
- Register 0 and spurious retire: issue_rd=0 -> inflight stays 0. rs_d=0 never stalls. wb_valid wb_rd=9 with cnt 0 -> overflow_err=1, persists through flush, cleared only by resetn=0.
- Flush and async reset: with pending=0x0000_0110, pulse flush -> pending=0 and inflight=0 next cycle. Drop resetn mid-cycle -> outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the register scoreboard: register index type,
// the hard-wired zero register, and the default outstanding-write counter type.
package cpu_pkg;

  localparam int SCB_CNT_W = 2;

  typedef logic [4:0] creg_t;

  localparam creg_t REG_ZERO = 5'd0;

  typedef logic [SCB_CNT_W-1:0] scb_cnt_t;

endpackage

// File: rtl/scb_counter.sv
// One per-register outstanding-write counter. It counts up on a tracked issue
// and down on a retire, and clears on flush. It refuses to step past either
// end, so an unexpected inc/dec can never wrap the count.
module scb_counter #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic is_zero,
  output logic is_one,
  output logic is_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == W'(1));
  assign is_max  = (&cnt_q);

  // Next count: flush wins, otherwise net +1/-1, with simultaneous inc+dec cancelling
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !is_max) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared asynchronously with the rest of the pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for late (non-forwardable from E) results such as
// loads and mul/div. It tracks outstanding writes per destination register
// and stalls decode on a source hazard, or when tracking capacity is exhausted.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W        = SCB_CNT_W,
  parameter int MAX_INFLIGHT = 4,
  localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic [4:0]       issue_rd,
  input  logic             issue_late,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [31:0]      pending,
  output logic [INF_W-1:0] inflight,
  output logic             overflow_err
);

  logic [31:0]      cnt_zero;
  logic [31:0]      cnt_one;
  logic [31:0]      cnt_max;
  logic             late_wr;
  logic             hz_s;
  logic             hz_t;
  logic             structural;
  logic             track;
  logic             wb_ok;
  logic [INF_W-1:0] inflight_q;
  logic [INF_W-1:0] inflight_d;
  logic             overflow_q;
  logic             overflow_d;

  // r0 is hard-wired zero: it reads as an idle counter that can never fill
  assign cnt_zero[0] = 1'b1;
  assign cnt_one[0]  = 1'b0;
  assign cnt_max[0]  = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_cnt
    scb_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .inc     (track && (issue_rd == creg_t'(r))),
      .dec     (wb_ok && (wb_rd == creg_t'(r))),
      .clr     (flush),
      .is_zero (cnt_zero[r]),
      .is_one  (cnt_one[r]),
      .is_max  (cnt_max[r])
    );
  end

  // Stall decision; a last outstanding write retiring now is covered by the W forward path
  always_comb begin
    hz_s        = (rs_d != REG_ZERO) && !cnt_zero[rs_d] &&
                  !(wb_valid && (wb_rd == rs_d) && cnt_one[rs_d]);
    hz_t        = (rt_d != REG_ZERO) && !cnt_zero[rt_d] &&
                  !(wb_valid && (wb_rd == rt_d) && cnt_one[rt_d]);
    late_wr     = issue_valid && issue_wr && issue_late && (issue_rd != REG_ZERO);
    structural  = late_wr && (cnt_max[issue_rd] ||
                  ((inflight_q == INF_W'(MAX_INFLIGHT)) && !wb_valid));
    issue_ready = !(issue_valid && (hz_s || hz_t || structural));
    track       = late_wr && issue_ready;
    wb_ok       = wb_valid && !cnt_zero[wb_rd];
  end

  // Total in-flight count and sticky spurious-retire flag; flush leaves the flag alone
  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else if (track && !wb_ok) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!track && wb_ok) begin
      inflight_d = inflight_q - INF_W'(1);
    end
    overflow_d = overflow_q || (wb_valid && !wb_ok);
  end

  // Aggregate state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending      = ~cnt_zero;
  assign inflight     = inflight_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard. Each stimulus cycle pushes its
// expected outputs into a queue, and a monitor pops and compares them at the
// falling edge. The reference model keeps plain integer counts per register.
module tb_reg_scoreboard;

  localparam int CNT_W   = 2;
  localparam int MAX_INF = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam int INF_W   = $clog2(MAX_INF + 1);

  typedef struct {
    string       tag;
    logic        ready;
    logic [31:0] pend;
    int          infl;
    logic        ovf;
  } exp_t;

  logic             clk;
  logic             resetn;
  logic             issue_valid;
  logic             issue_wr;
  logic [4:0]       issue_rd;
  logic             issue_late;
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic [31:0]      pending;
  logic [INF_W-1:0] inflight;
  logic             overflow_err;

  int   m_cnt [32];
  int   m_infl;
  bit   m_ovf;
  exp_t exp_q[$];
  int   check_cnt;
  int   pass_cnt;

  reg_scoreboard #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INF)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_late   (issue_late),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .pending      (pending),
    .inflight     (inflight),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
  endtask

  function automatic void modelReset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_infl = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic logic [31:0] modelPending();
    logic [31:0] p = '0;
    for (int i = 1; i < 32; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  // One cycle: drive inputs, predict this cycle's outputs, then advance the model past the edge
  task automatic applyStimulus(input string tag, input bit v, input bit wr, input int rd, input bit late,
                               input int rs, input int rt, input bit wbv, input int wbrd, input bit fl);
    exp_t e;
    bit   hz_s, hz_t, cand, strc, rdy, trk, ret_ok;
    @(posedge clk);
    #1;
    issue_valid = v;  issue_wr = wr;  issue_rd = 5'(rd); issue_late = late;
    rs_d = 5'(rs);    rt_d = 5'(rt);  wb_valid = wbv;    wb_rd = 5'(wbrd); flush = fl;
    hz_s = (rs != 0) && (m_cnt[rs] > 0) && !(wbv && wbrd == rs && m_cnt[rs] == 1);
    hz_t = (rt != 0) && (m_cnt[rt] > 0) && !(wbv && wbrd == rt && m_cnt[rt] == 1);
    cand = v && wr && late && (rd != 0);
    strc = cand && ((m_cnt[rd] == MAXC) || (m_infl == MAX_INF && !wbv));
    rdy  = !(v && (hz_s || hz_t || strc));
    e.tag = tag; e.ready = rdy; e.pend = modelPending(); e.infl = m_infl; e.ovf = m_ovf;
    exp_q.push_back(e);
    trk    = cand && rdy;
    ret_ok = wbv && (wbrd != 0) && (m_cnt[wbrd] > 0);
    if (wbv && !ret_ok) m_ovf = 1'b1;
    if (fl) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_infl = 0;
    end else begin
      if (trk)    begin m_cnt[rd]++;   m_infl++; end
      if (ret_ok) begin m_cnt[wbrd]--; m_infl--; end
    end
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every presented cycle against the queued prediction
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput({e.tag, ".ready"},    32'(issue_ready),  32'(e.ready));
        checkOutput({e.tag, ".pending"},  pending,           e.pend);
        checkOutput({e.tag, ".inflight"}, 32'(inflight),     32'(e.infl));
        checkOutput({e.tag, ".overflow"}, 32'(overflow_err), 32'(e.ovf));
      end
    end
  end

  initial begin
    check_cnt = 0; pass_cnt = 0;
    issue_valid = 0; issue_wr = 0; issue_rd = 0; issue_late = 0;
    rs_d = 0; rt_d = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    resetn = 1'b0;
    modelReset();
    #13;
    checkOutput("reset.ready",    32'(issue_ready),  32'd1);
    checkOutput("reset.pending",  pending,           32'd0);
    checkOutput("reset.inflight", 32'(inflight),     32'd0);
    checkOutput("reset.overflow", 32'(overflow_err), 32'd0);
    resetn = 1'b1;

    idle("post_reset");

    // Load-use on r8, released by the same-cycle retire
    applyStimulus("lu_issue",  1, 1, 8, 1, 0, 0, 0, 0, 0);
    applyStimulus("lu_stall",  1, 0, 0, 0, 8, 0, 0, 0, 0);
    applyStimulus("lu_wbfwd",  1, 0, 0, 0, 8, 0, 1, 8, 0);
    idle("lu_clear");

    // Same-cycle issue and retire on r5
    applyStimulus("sc_issue",  1, 1, 5, 1, 0, 0, 0, 0, 0);
    applyStimulus("sc_both",   1, 1, 5, 1, 0, 0, 1, 5, 0);
    idle("sc_hold");
    applyStimulus("sc_drain",  0, 0, 0, 0, 0, 0, 1, 5, 0);

    // Per-register saturation on r3
    for (int i = 0; i < 3; i++) applyStimulus("sat_fill", 1, 1, 3, 1, 0, 0, 0, 0, 0);
    applyStimulus("sat_stall", 1, 1, 3, 1, 0, 0, 0, 0, 0);
    applyStimulus("sat_ret",   0, 0, 0, 0, 0, 0, 1, 3, 0);
    applyStimulus("sat_go",    1, 1, 3, 1, 0, 0, 0, 0, 0);
    applyStimulus("sat_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Global in-flight limit
    for (int r = 1; r <= 4; r++) applyStimulus("inf_fill", 1, 1, r, 1, 0, 0, 0, 0, 0);
    applyStimulus("inf_stall", 1, 1, 6, 1, 0, 0, 0, 0, 0);
    applyStimulus("inf_wb",    1, 1, 6, 1, 0, 0, 1, 1, 0);
    idle("inf_hold");
    applyStimulus("inf_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // r0 is never tracked; spurious retire is sticky through flush
    applyStimulus("z_issue",   1, 1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("z_src",     1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("z_spur",    0, 0, 0, 0, 0, 0, 1, 9, 0);
    applyStimulus("z_flush",   0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("z_sticky");

    // Flush with pending = 0x110, then async reset mid-cycle
    applyStimulus("fl_i4",     1, 1, 4, 1, 0, 0, 0, 0, 0);
    applyStimulus("fl_i8",     1, 1, 8, 1, 0, 0, 0, 0, 0);
    idle("fl_pend");
    applyStimulus("fl_flush",  0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("fl_done");
    applyStimulus("rs_i4",     1, 1, 4, 1, 0, 0, 0, 0, 0);
    applyStimulus("rs_i8",     1, 1, 8, 1, 0, 0, 0, 0, 0);
    idle("rs_pend");
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst.pending",  pending,           32'd0);
    checkOutput("async_rst.inflight", 32'(inflight),     32'd0);
    checkOutput("async_rst.overflow", 32'(overflow_err), 32'd0);
    checkOutput("async_rst.ready",    32'(issue_ready),  32'd1);
    modelReset();
    #3;
    resetn = 1'b1;

    // Randomized traffic on a small register window so hazards and limits occur often
    for (int n = 0; n < 400; n++) begin
      int  busy[$];
      bit  wbv;
      int  wbr;
      for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) busy.push_back(i);
      wbv = 1'b0; wbr = 0;
      if (busy.size() > 0 && $urandom_range(0, 99) < 45) begin
        wbv = 1'b1;
        wbr = busy[$urandom_range(0, busy.size() - 1)];
      end
      applyStimulus("rand", 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 80),
                    int'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 75),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    wbv, wbr, 1'($urandom_range(0, 99) < 3));
    end
    idle("tail");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      check_cnt++;
      $display("[TB] FAIL drain_timeout actual=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
